jesd204b_dl_char_replace: RTL
=============================

// Module: jesd204b_dl_char_replace
// PURPOSE
//  Transmit data-link-layer alignment character replacement for one lane.
//  Consumes the per-octet eof/eom markers from the frame marker, already aligned to the lane data,
//  and substitutes /F/ (K28.7, 8'hFC) or /A/ (K28.3, 8'h7C) at frame/multiframe ends per JESD204B.
//  Sits between the transport-layer lane mapper and the 8b/10b encoder; emits data plus per-octet K flags.
// PARAMETERS
//  LANE_DATA_WIDTH  32     lane word width in bits; must equal 8*OCTET_PER_SENT
//  OCTET_PER_SENT   4      octets per clock; octet i = data[8i+7:8i], octet 0 first in time
//  K_F              8'hFC  /F/ frame alignment character
//  K_A              8'h7C  /A/ multiframe alignment character
// PORTS
//  clk       in   1                  lane clock
//  reset     in   1                  synchronous, active-high
//  enable    in   1                  1 = user-data phase, replacement active; 0 = transparent pass-through
//  scr_en    in   1                  1 = scrambled-link rules, 0 = unscrambled rules; quasi-static
//  data_in   in   LANE_DATA_WIDTH    lane octets, aligned cycle-for-cycle with eof/eom
//  eof       in   OCTET_PER_SENT     1 marks last octet of a frame
//  eom       in   OCTET_PER_SENT     1 marks last octet of a multiframe (eom implies eof)
//  data_out  out  LANE_DATA_WIDTH    octets after replacement
//  charisk   out  OCTET_PER_SENT     1 = octet in data_out is a K character
// BEHAVIOUR
//  - Reset: data_out=0, charisk=0, prev_oct=0, prev_k=0, prev_vld=0.
//  - Latency: exactly 1 clk, data_in/eof/eom -> data_out/charisk; no backpressure, one word per clk.
//  - enable=0: data_out=data_in, charisk=0 after 1 clk; prev_vld cleared.
//  - Octets are processed in order 0..N-1; state chains across octets inside one word and across words.
//  - Unscrambled (scr_en=0), at octet i with eof[i]=1 and original value d:
//    * eom[i]=1: if prev_vld && d==prev_oct -> emit K_A, K=1 (regardless of prev_k).
//    * else eof only: if prev_vld && d==prev_oct && !prev_k -> emit K_F, K=1.
//    * otherwise emit d, K=0.
//    * then prev_oct<=d (original value, never the substituted char), prev_k<=K, prev_vld<=1.
//  - Scrambled (scr_en=1): eom[i] && d==K_A -> K_A,K=1; eof[i] && !eom[i] && d==K_F -> K_F,K=1;
//    prev_* not used for the decision but still updated as above.
//  - Octets with eof[i]=0 pass unchanged, K=0; eom[i]=1 with eof[i]=0 is treated as eof[i]=1.
//  - Multiple eof bits in one word (F=1/2) resolve left-to-right: octet i compares against octet i-1's
//    updated state from the same word, not the registered value.
//  - First eof after reset or enable rising: prev_vld=0 -> never replaced.
//  - reset mid-word: output word of that cycle is the reset value; no partial replacement survives.
// STRUCTURE
//  - Shared package jesd204b_dl_pkg: K_F/K_A constants, octet-index helpers, per-octet struct {oct,k}.
//  - Sub-module jesd204b_dl_octet_repl: combinational single-octet decision
//    (d, eof, eom, scr_en, prev_oct/prev_k/prev_vld in -> oct/k out plus next prev_* out);
//    the top module instantiates OCTET_PER_SENT copies chained in generate and registers the outputs and prev_*.
// TESTING
//  1 reset held 3 clk, random data -> data_out=0, charisk=0 throughout; first word after release is 1 clk late.
//  2 enable=1, scr_en=0, F=4: words 0xAA112233 then 0xAA445566, eof=4'b1000 on both ->
//    second word out 0xFC445566, charisk=4'b1000; first word unchanged.
//  3 Three consecutive frames ending 0xAA, eof only -> outputs K_F, data 0xAA, K_F
//    (prev_k blocks the second replacement).
//  4 Same as 3, but the third end is eom=4'b1000 -> third octet K_A, charisk=1 even though prev_k=1.
//  5 F=1, data 0x55555555, eof=4'b1111 after a prior frame ended 0x55 ->
//    data_out 0x55FC55FC, charisk=4'b0101.
//  6 scr_en=1: eof octet 0xFC -> K_F, K=1; eom octet 0x7C -> K_A, K=1; eof octet 0x7C without eom ->
//    passes unchanged, K=0. enable toggled 0->1: first eof is not replaced.

Source files
------------

// File: rtl/jesd204b_dl_pkg.sv
// Shared JESD204B data-link definitions: alignment characters, octet indexing
// and the per-octet replacement result type.
package jesd204b_dl_pkg;

    localparam logic [7:0] K_F_CHAR = 8'hFC;  // K28.7, /F/
    localparam logic [7:0] K_A_CHAR = 8'h7C;  // K28.3, /A/

    typedef struct packed {
        logic [7:0] oct;
        logic       k;
    } octet_t;

    // Octet i occupies data[8i+7:8i]; octet 0 is first in time.
    function automatic int oct_lsb(input int idx);
        return 8 * idx;
    endfunction

endpackage

// File: rtl/jesd204b_dl_char_replace_if.sv
// Lane-side bus of the alignment character replacer: octets and frame markers
// in, replaced octets and K flags out.
interface jesd204b_dl_char_replace_if #(
    parameter int LANE_DATA_WIDTH = 32,
    parameter int OCTET_PER_SENT  = 4
);
    logic                       enable;
    logic                       scr_en;
    logic [LANE_DATA_WIDTH-1:0] data_in;
    logic [OCTET_PER_SENT-1:0]  eof;
    logic [OCTET_PER_SENT-1:0]  eom;
    logic [LANE_DATA_WIDTH-1:0] data_out;
    logic [OCTET_PER_SENT-1:0]  charisk;

    modport master (
        output enable, scr_en, data_in, eof, eom,
        input  data_out, charisk
    );

    modport slave (
        input  enable, scr_en, data_in, eof, eom,
        output data_out, charisk
    );
endinterface

// File: rtl/jesd204b_dl_octet_repl.sv
// Single-octet /F/ /A/ substitution decision; combinational, chained by the
// parent so each octet sees the state left by the octet before it.
module jesd204b_dl_octet_repl
    import jesd204b_dl_pkg::*;
#(
    parameter logic [7:0] K_F = K_F_CHAR,
    parameter logic [7:0] K_A = K_A_CHAR
) (
    input  logic [7:0] d_i,
    input  logic       eof_i,
    input  logic       eom_i,
    input  logic       scr_en_i,
    input  logic [7:0] prev_oct_i,
    input  logic       prev_k_i,
    input  logic       prev_vld_i,
    output octet_t     out_o,
    output logic [7:0] prev_oct_o,
    output logic       prev_k_o,
    output logic       prev_vld_o
);

    logic is_end;
    logic same_as_prev;
    logic repl_a;
    logic repl_f;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        is_end       = eof_i | eom_i;
        same_as_prev = prev_vld_i && (d_i == prev_oct_i);

        if (scr_en_i) begin
            repl_a = eom_i && (d_i == K_A);
            repl_f = eof_i && !eom_i && (d_i == K_F);
        end else begin
            // /A/ ignores prev_k; /F/ may not follow a replaced frame end.
            repl_a = eom_i && same_as_prev;
            repl_f = eof_i && !eom_i && same_as_prev && !prev_k_i;
        end

        out_o.oct = d_i;
        out_o.k   = 1'b0;
        if (repl_a) begin
            out_o.oct = K_A;
            out_o.k   = 1'b1;
        end else if (repl_f) begin
            out_o.oct = K_F;
            out_o.k   = 1'b1;
        end

        prev_oct_o = prev_oct_i;
        prev_k_o   = prev_k_i;
        prev_vld_o = prev_vld_i;
        if (is_end) begin
            // Later comparisons use the original octet, never the substituted char.
            prev_oct_o = d_i;
            prev_k_o   = repl_a | repl_f;
            prev_vld_o = 1'b1;
        end
    end

endmodule

// File: rtl/jesd204b_dl_char_replace.sv
// Per-lane TX alignment character replacement: one word per clock, one clock
// of latency, octets resolved in time order through a chain of deciders.
module jesd204b_dl_char_replace
    import jesd204b_dl_pkg::*;
#(
    parameter int         LANE_DATA_WIDTH = 32,
    parameter int         OCTET_PER_SENT  = 4,
    parameter logic [7:0] K_F             = K_F_CHAR,
    parameter logic [7:0] K_A             = K_A_CHAR
) (
    input  logic clk,
    input  logic reset,
    jesd204b_dl_char_replace_if.slave bus
);

    logic [LANE_DATA_WIDTH-1:0] data_out_q;
    logic [OCTET_PER_SENT-1:0]  charisk_q;
    logic [7:0]                 prev_oct_q;
    logic                       prev_k_q;
    logic                       prev_vld_q;

    logic [LANE_DATA_WIDTH-1:0] data_d;
    logic [OCTET_PER_SENT-1:0]  charisk_d;

    logic [7:0] chain_oct [OCTET_PER_SENT+1];
    logic       chain_k   [OCTET_PER_SENT+1];
    logic       chain_vld [OCTET_PER_SENT+1];
    octet_t     repl      [OCTET_PER_SENT];

    assign chain_oct[0] = prev_oct_q;
    assign chain_k[0]   = prev_k_q;
    assign chain_vld[0] = prev_vld_q;

    for (genvar i = 0; i < OCTET_PER_SENT; i++) begin : g_oct
        jesd204b_dl_octet_repl #(
            .K_F (K_F),
            .K_A (K_A)
        ) u_repl (
            .d_i        (bus.data_in[oct_lsb(i) +: 8]),
            .eof_i      (bus.eof[i]),
            .eom_i      (bus.eom[i]),
            .scr_en_i   (bus.scr_en),
            .prev_oct_i (chain_oct[i]),
            .prev_k_i   (chain_k[i]),
            .prev_vld_i (chain_vld[i]),
            .out_o      (repl[i]),
            .prev_oct_o (chain_oct[i+1]),
            .prev_k_o   (chain_k[i+1]),
            .prev_vld_o (chain_vld[i+1])
        );

        assign data_d[oct_lsb(i) +: 8] = repl[i].oct;
        assign charisk_d[i]            = repl[i].k;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            charisk_q  <= '0;
            prev_oct_q <= '0;
            prev_k_q   <= 1'b0;
            prev_vld_q <= 1'b0;
        end else if (!bus.enable) begin
            // Pass-through; the first frame end after enable rises is never replaced.
            data_out_q <= bus.data_in;
            charisk_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            data_out_q <= data_d;
            charisk_q  <= charisk_d;
            prev_oct_q <= chain_oct[OCTET_PER_SENT];
            prev_k_q   <= chain_k[OCTET_PER_SENT];
            prev_vld_q <= chain_vld[OCTET_PER_SENT];
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.charisk  = charisk_q;

endmodule
